regfile_param: RTL and testbench

- Parametrised successor to the single-cycle MIPS register block.
- Provides NUM_RD combinational read ports and one normal write port, plus a privileged write port for protected registers (r26–r31: k0/k1/gp/sp/fp/ra).
- After reset, a hardware clear sweep initialises every register, so no file-based memory init is needed.
- Optional write-to-read bypass. Sits between decode and writeback in the single-cycle datapath.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rd_port.sv | 33 +++
 rtl/regfile_param.sv | 111 +++++++++++
 tb/tb_regfile_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised MIPS register file.
package regfile_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

    localparam int REG_ZERO = 0;
    localparam int REG_K0   = 26;
    localparam int REG_K1   = 27;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_FP   = 30;
    localparam int REG_RA   = 31;

    // r0 plus the kernel/stack/return registers r26..r31
    localparam logic [31:0] PROT_MASK_DEFAULT = 32'hFC00_0001;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero register, init blanking and same-cycle write bypass.
module regfile_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              run,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pw_acc,
    input  logic [ADDR_W-1:0] pw_addr,
    input  logic [DATA_W-1:0] pw_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        if (run && addr != '0) begin
            data = arr_data;
            if (BYPASS) begin
                if (pw_acc && pw_addr == addr) begin
                    data = pw_data;
                end else if (wr_acc && wr_addr == addr) begin
                    data = wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Register file with NUM_RD read ports, a normal and a privileged write port,
// and a post-reset clear sweep of DEPTH cycles before ready rises.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int                      DATA_W    = 32,
    parameter int                      ADDR_W    = 5,
    parameter int                      NUM_RD    = 2,
    parameter logic [(2**ADDR_W)-1:0]  PROT_MASK = PROT_MASK_DEFAULT,
    parameter bit                      BYPASS    = 1'b1,
    parameter logic [DATA_W-1:0]       INIT_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pw_en,
    input  logic [ADDR_W-1:0]          pw_addr,
    input  logic [DATA_W-1:0]          pw_data,
    output logic                       ready,
    output logic                       wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    rf_state_t         state;
    rf_state_t         state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run;
    logic              wr_acc;
    logic              pw_acc;
    logic              drop_nxt;

    assign run   = (state == RF_RUN);
    assign ready = run;

    // privileged port wins an address collision, so the normal write yields
    assign wr_acc = run && wr_en && !PROT_MASK[wr_addr] && !(pw_en && pw_addr == wr_addr);
    assign pw_acc = run && pw_en && (pw_addr != '0);

    assign drop_nxt = (wr_en && !wr_acc) || (pw_en && !pw_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == RF_INIT && (&cnt)) begin
            state_nxt = RF_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= drop_nxt;
            if (state == RF_INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // No reset on the array; r0 is never stored since every read of it returns 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_INIT && cnt != '0) begin
                mem[cnt] <= INIT_VAL;
            end
            if (wr_acc) begin
                mem[wr_addr] <= wr_data;
            end
            if (pw_acc) begin
                mem[pw_addr] <= pw_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rd (
            .addr     (addr_k),
            .arr_data (mem[addr_k]),
            .run      (run),
            .wr_acc   (wr_acc),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .pw_acc   (pw_acc),
            .pw_addr  (pw_addr),
            .pw_data  (pw_data),
            .data     (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param; a second instance with BYPASS=0 shares all inputs.
module tb_regfile_param;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] rd_data_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pw_en;
    logic [4:0]  pw_addr;
    logic [31:0] pw_data;
    logic        ready;
    logic        ready_nb;
    logic        wr_drop;
    logic        wr_drop_nb;

    int compared   = 0;
    int mismatched = 0;

    regfile_param u_dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .pw_en   (pw_en),
        .pw_addr (pw_addr),
        .pw_data (pw_data),
        .ready   (ready),
        .wr_drop (wr_drop)
    );

    regfile_param #(.BYPASS(1'b0)) u_nb (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_data (rd_data_nb),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .pw_en   (pw_en),
        .pw_addr (pw_addr),
        .pw_data (pw_data),
        .ready   (ready_nb),
        .wr_drop (wr_drop_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pw_en = 1'b0; pw_addr = '0; pw_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_addr = {5'd3, 5'd5};
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        compared++;
        if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", ready); end
        compared++;
        if (wr_drop !== 1'b0) begin mismatched++; $display("FAIL reset_wr_drop got %b want 0", wr_drop); end
        compared++;
        if (rd_data !== 64'd0) begin mismatched++; $display("FAIL reset_rd_blank got %h want 0", rd_data); end
    endtask

    // Counts cycles with ready low, starting with the one just after the reset edge
    task automatic test_sweep();
        int n = 1;
        while (!ready && n < 100) begin
            step();
            if (!ready) n++;
        end
        compared++;
        if (n !== 32) begin mismatched++; $display("FAIL sweep_len got %0d want 32", n); end
        compared++;
        if (ready !== 1'b1) begin mismatched++; $display("FAIL sweep_ready got %b want 1", ready); end
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(31 - r), 5'(r)};
            #1;
            compared++;
            if (rd_data !== 64'd0) begin
                mismatched++;
                $display("FAIL sweep_init r%0d got %h want 0", r, rd_data);
            end
        end
    endtask

    task automatic test_normal_write();
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
        rd_addr = {5'd8, 5'd8};
        #1;
        compared++;
        if (rd_data[31:0] !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL wr_bypass got %h want deadbeef", rd_data[31:0]); end
        step();
        idle_inputs();
        #1;
        compared++;
        if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin mismatched++; $display("FAIL wr_r8 got %h want deadbeefdeadbeef", rd_data); end
        compared++;
        if (wr_drop !== 1'b0) begin mismatched++; $display("FAIL wr_r8_drop got %b want 0", wr_drop); end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd5;
        rd_addr = {5'd8, 5'd0};
        #1;
        compared++;
        if (rd_data[31:0] !== 32'd0) begin mismatched++; $display("FAIL wr_r0_bypass got %h want 0", rd_data[31:0]); end
        step();
        idle_inputs();
        #1;
        compared++;
        if (wr_drop !== 1'b1) begin mismatched++; $display("FAIL wr_r0_drop got %b want 1", wr_drop); end
        compared++;
        if (rd_data[31:0] !== 32'd0) begin mismatched++; $display("FAIL wr_r0_read got %h want 0", rd_data[31:0]); end
        step();
        compared++;
        if (wr_drop !== 1'b0) begin mismatched++; $display("FAIL drop_pulse got %b want 0", wr_drop); end
    endtask

    task automatic test_protection();
        wr_en = 1'b1; wr_addr = 5'(REG_SP); wr_data = 32'h1234;
        rd_addr = {5'd0, 5'(REG_SP)};
        step();
        idle_inputs();
        #1;
        compared++;
        if (wr_drop !== 1'b1) begin mismatched++; $display("FAIL prot_sp_drop got %b want 1", wr_drop); end
        compared++;
        if (rd_data[31:0] !== 32'd0) begin mismatched++; $display("FAIL prot_sp_kept got %h want 0", rd_data[31:0]); end
        pw_en = 1'b1; pw_addr = 5'(REG_SP); pw_data = 32'h7FFF_EFFC;
        step();
        idle_inputs();
        #1;
        compared++;
        if (rd_data[31:0] !== 32'h7FFF_EFFC) begin mismatched++; $display("FAIL pw_sp got %h want 7fffeffc", rd_data[31:0]); end
        compared++;
        if (wr_drop !== 1'b0) begin mismatched++; $display("FAIL pw_sp_drop got %b want 0", wr_drop); end
        // r25 sits just below the protected range
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'hAA;
        pw_en = 1'b1; pw_addr = 5'd0; pw_data = 32'h77;
        rd_addr = {5'd0, 5'd25};
        step();
        idle_inputs();
        #1;
        compared++;
        if (wr_drop !== 1'b1) begin mismatched++; $display("FAIL pw_r0_drop got %b want 1", wr_drop); end
        compared++;
        if (rd_data !== {32'd0, 32'hAA}) begin mismatched++; $display("FAIL r25_r0 got %h want 00000000000000aa", rd_data); end
        wr_en = 1'b1; wr_addr = 5'(REG_RA); wr_data = 32'h55;
        rd_addr = {5'd0, 5'(REG_RA)};
        step();
        idle_inputs();
        #1;
        compared++;
        if (wr_drop !== 1'b1 || rd_data[31:0] !== 32'd0) begin
            mismatched++; $display("FAIL prot_ra got drop=%b data=%h want drop=1 data=0", wr_drop, rd_data[31:0]);
        end
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd1;
        pw_en = 1'b1; pw_addr = 5'd9; pw_data = 32'd2;
        rd_addr = {5'd0, 5'd9};
        #1;
        compared++;
        if (rd_data[31:0] !== 32'd2) begin mismatched++; $display("FAIL coll_bypass got %h want 2", rd_data[31:0]); end
        step();
        idle_inputs();
        #1;
        compared++;
        if (rd_data[31:0] !== 32'd2) begin mismatched++; $display("FAIL coll_r9 got %h want 2", rd_data[31:0]); end
        compared++;
        if (wr_drop !== 1'b1) begin mismatched++; $display("FAIL coll_drop got %b want 1", wr_drop); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h11;
        pw_en = 1'b1; pw_addr = 5'd12; pw_data = 32'h12;
        rd_addr = {5'd12, 5'd11};
        step();
        wr_addr = 5'd11; wr_data = 32'h21;
        pw_en = 1'b0;
        #1;
        compared++;
        if (wr_drop !== 1'b0) begin mismatched++; $display("FAIL dual_drop got %b want 0", wr_drop); end
        compared++;
        if (rd_data_nb !== {32'h12, 32'h11}) begin mismatched++; $display("FAIL dual_commit got %h want 0000001200000011", rd_data_nb); end
        step();
        idle_inputs();
        #1;
        compared++;
        if (rd_data[31:0] !== 32'h21) begin mismatched++; $display("FAIL b2b_r11 got %h want 21", rd_data[31:0]); end
    endtask

    task automatic test_bypass_off();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd3;
        rd_addr = {5'd0, 5'd10};
        #1;
        compared++;
        if (rd_data_nb[31:0] !== 32'd0) begin mismatched++; $display("FAIL nb_same_cycle got %h want 0", rd_data_nb[31:0]); end
        compared++;
        if (rd_data[31:0] !== 32'd3) begin mismatched++; $display("FAIL byp_same_cycle got %h want 3", rd_data[31:0]); end
        step();
        idle_inputs();
        #1;
        compared++;
        if (rd_data_nb[31:0] !== 32'd3) begin mismatched++; $display("FAIL nb_next_cycle got %h want 3", rd_data_nb[31:0]); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        compared++;
        if (ready !== 1'b0) begin mismatched++; $display("FAIL mid_sweep_ready got %b want 0", ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!ready) n++;
        end
        // r1 was already swept; a write landing now would survive
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h55;
        step();
        if (!ready) n++;
        idle_inputs();
        #1;
        compared++;
        if (wr_drop !== 1'b1) begin mismatched++; $display("FAIL init_drop got %b want 1", wr_drop); end
        while (!ready && n < 100) begin
            step();
            if (!ready) n++;
        end
        compared++;
        if (n !== 32) begin mismatched++; $display("FAIL resweep_len got %0d want 32", n); end
        rd_addr = {5'd9, 5'd1};
        #1;
        compared++;
        if (rd_data !== 64'd0) begin mismatched++; $display("FAIL init_no_write got %h want 0", rd_data); end
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle_inputs();
        test_reset();
        test_sweep();
        test_normal_write();
        test_protection();
        test_collision();
        test_back_to_back();
        test_bypass_off();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
